// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation scheduler: FSM encoding, parameter
// defaults and a width helper used for zone-index ports.
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_GUARD = 2'd2
    } irr_state_t;

    localparam int ZONES_DEFAULT       = 4;
    localparam int TICK_W_DEFAULT      = 8;
    localparam int GUARD_TICKS_DEFAULT = 2;

    // Index width that stays legal (>= 1 bit) even for a single-zone build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irrigation_scheduler_rr_arbiter.sv
// Round-robin zone arbiter: searches from the zone after the last accepted
// grant, wrapping at ZONES-1; pointer advances only when the grant is accepted.
module rr_arbiter
    import irrigation_pkg::*;
#(
    parameter int ZONES = ZONES_DEFAULT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ZONES-1:0]               request,
    input  logic                           accept,
    output logic [ZONES-1:0]               grant,
    output logic [idx_width(ZONES)-1:0]    grant_idx,
    output logic                           grant_valid
);

    localparam int IDX_W = idx_width(ZONES);
    localparam int CW    = IDX_W + 1;

    logic [IDX_W-1:0] start_reg;
    logic [IDX_W-1:0] start_next;
    logic [CW-1:0]    cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < ZONES; i++) begin
            cand = {1'b0, start_reg} + CW'(i);
            if (cand >= CW'(ZONES)) begin
                cand = cand - CW'(ZONES);
            end
            if (!grant_valid && request[cand[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        start_next = start_reg;
        if (accept && grant_valid) begin
            start_next = (grant_idx == IDX_W'(ZONES - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            start_reg <= '0;
        end else begin
            start_reg <= start_next;
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation valve scheduler: grants one zone at a time round-robin, holds the
// valve open for the zone's duration in slow ticks, then enforces a guard gap.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int ZONES       = ZONES_DEFAULT,
    parameter int TICK_W      = TICK_W_DEFAULT,
    parameter int GUARD_TICKS = GUARD_TICKS_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          slow_tick,
    input  logic [ZONES-1:0]              request,
    input  logic [ZONES*TICK_W-1:0]       duration,
    input  logic                          abort,
    output logic [ZONES-1:0]              valve,
    output logic [idx_width(ZONES)-1:0]   active_zone,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = idx_width(ZONES);
    localparam logic [TICK_W-1:0] ONE        = TICK_W'(1);
    localparam logic [TICK_W-1:0] GUARD_LOAD = TICK_W'((GUARD_TICKS < 1) ? 1 : GUARD_TICKS);

    irr_state_t         state_reg;
    logic [ZONES-1:0]   valve_reg;
    logic [IDX_W-1:0]   zone_reg;
    logic [TICK_W-1:0]  cnt_reg;
    logic               done_reg;

    logic [TICK_W-1:0]  dur_arr [ZONES];
    logic [TICK_W-1:0]  grant_dur;
    logic [TICK_W-1:0]  load_dur;
    logic [ZONES-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               accept;

    generate
        for (genvar gi = 0; gi < ZONES; gi++) begin : g_dur
            assign dur_arr[gi] = duration[gi*TICK_W +: TICK_W];
        end
    endgenerate

    // A zero duration still opens the valve for one tick.
    assign grant_dur = dur_arr[grant_idx];
    assign load_dur  = (grant_dur == '0) ? ONE : grant_dur;
    assign accept    = (state_reg == ST_IDLE) && grant_valid;

    rr_arbiter #(
        .ZONES (ZONES)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .accept      (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            valve_reg <= '0;
            zone_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    valve_reg <= '0;
                    // A tick coinciding with the grant is deliberately not counted.
                    if (grant_valid) begin
                        state_reg <= ST_OPEN;
                        cnt_reg   <= load_dur;
                        zone_reg  <= grant_idx;
                        valve_reg <= grant;
                    end
                end
                ST_OPEN: begin
                    // Abort / request drop takes priority over the final tick: no done.
                    if (abort || !request[zone_reg]) begin
                        valve_reg <= '0;
                        cnt_reg   <= GUARD_LOAD;
                        state_reg <= ST_GUARD;
                    end else if (slow_tick) begin
                        if (cnt_reg > ONE) begin
                            cnt_reg <= cnt_reg - ONE;
                        end else begin
                            valve_reg <= '0;
                            done_reg  <= 1'b1;
                            cnt_reg   <= GUARD_LOAD;
                            state_reg <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    valve_reg <= '0;
                    if (slow_tick) begin
                        if (cnt_reg > ONE) begin
                            cnt_reg <= cnt_reg - ONE;
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valve_reg <= '0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign valve       = valve_reg;
    assign active_zone = zone_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter ZONES, default 4: number of irrigation zones/valves.
REQ-002 Parameter TICK_W, default 8: width of per-zone duration and internal tick counter.
REQ-003 Parameter GUARD_TICKS, default 2: dead time, in slow ticks, between closing one valve and opening the next; SHALL be >= 1.
REQ-004 clock  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 slow_tick  input  1  one-cycle timebase pulse from the clock-division chain.
REQ-007 request  input  ZONES  per-zone irrigation request, level-sensitive.
REQ-008 duration  input  ZONES*TICK_W  packed per-zone open time in slow ticks; zone i occupies bits [i*TICK_W +: TICK_W].
REQ-009 abort  input  1  closes the open valve immediately.
REQ-010 valve  output  ZONES  valve drive, one-hot or zero, registered.
REQ-011 active_zone  output  clog2(ZONES)  index of the last granted zone, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion of an open period.

Function
REQ-014 FSM states SHALL be IDLE, OPEN and GUARD.
REQ-015 IDLE: if any request bit is high, grant one zone round-robin, starting at the index after the last granted zone and wrapping from ZONES-1 to 0; after reset the search SHALL start at zone 0.
REQ-016 On the grant cycle, the FSM SHALL move to OPEN, load the counter with the zone's duration (0 treated as 1), update active_zone, and drive the one-hot valve on the next cycle.
REQ-017 A slow_tick coincident with the grant cycle SHALL NOT decrement the counter.
REQ-018 OPEN: each slow_tick with counter > 1 SHALL decrement the counter.
REQ-019 OPEN: a slow_tick with counter == 1 SHALL clear valve, pulse done for one cycle, load GUARD_TICKS and enter GUARD.
REQ-020 OPEN: abort high, or the granted request bit low, SHALL clear valve on the next edge and enter GUARD with GUARD_TICKS loaded; done SHALL NOT pulse.
REQ-021 When abort and the final slow_tick coincide, abort SHALL win and done SHALL stay low.
REQ-022 GUARD: valve SHALL be all-zero; each slow_tick SHALL decrement the counter; a tick at counter == 1 SHALL return the FSM to IDLE.
REQ-023 Request changes during GUARD SHALL be ignored until IDLE.
REQ-024 At most one valve bit SHALL be high in any cycle; no valve SHALL open within GUARD_TICKS ticks of another closing.
REQ-025 The counter SHALL never wrap below zero.

Reset
REQ-026 With reset low at a clock edge: FSM = IDLE, valve = 0, active_zone = 0, busy = 0, done = 0, counter = 0, round-robin pointer set so the next search starts at zone 0.
REQ-027 Reset during OPEN SHALL close the valve at that same edge, with no GUARD period and no done pulse.

Structure
REQ-028 FSM state encoding and GUARD_TICKS default SHALL live in a shared package, irrigation_pkg.
REQ-029 The round-robin grant logic SHALL be a sub-module, rr_arbiter (ZONES-wide request in; one-hot grant and index out; pointer update on accept).
REQ-030 The block SHALL contain no derived clocks; slow_tick SHALL be used only as an enable.

Verification
REQ-031 request=4'b0001, duration0=3, tick every 10 cycles -> valve=0001 for exactly 3 ticks, done pulse once, then 2 guard ticks, busy low afterwards.
REQ-032 request=4'b1111, all durations=1 -> grants in order 0,1,2,3,0; valve never overlaps; each pair of openings is separated by 2 ticks.
REQ-033 Zone 2 open with duration 5; abort asserted after 2 ticks -> valve=0 on the next edge, no done pulse, GUARD entered.
REQ-034 duration1=0 with request=4'b0010 -> valve open 1 tick, done pulses.
REQ-035 Reset low mid-OPEN -> all outputs 0 on the next edge; after release with request=4'b1000, zone 3 is granted and the search restarts at index 0.
REQ-036 slow_tick on the grant cycle with duration=2 -> valve stays open for 2 subsequent ticks, not 1.
